// File: rtl/pwm_pkg.sv
// Shared constants for the PWM duty sequencer: default duty width, duty ceiling
// and the controller's state encoding.
package pwm_pkg;

  localparam int DW       = 3;
  localparam int DUTY_MAX = 2**DW - 1;

  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_STEP = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

endpackage

// File: rtl/pwm_step_timer.sv
// Ramp pacing counter: counts 0..STEP_DIV-1 while enabled and flags the last
// count, so the controller takes one step per STEP_DIV clocks spent waiting.
module pwm_step_timer #(
  parameter int STEP_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty sequencer in front of the PWM generator: takes target-duty commands and
// reaches them by a direct sync load or a paced inc/dec ramp, keeping a shadow duty.
//
// state  | meaning
// INIT   | re-synchronise the generator to INIT_DUTY after reset
// IDLE   | ready for a command
// LOAD   | drive pwm_load with the target duty
// WAIT   | pace the ramp until the step timer expires
// STEP   | issue one inc or dec pulse toward the target
// FIN    | pulse done, then return to IDLE
module pwm_ramp_ctrl #(
  parameter int DW        = 3,
  parameter int STEP_DIV  = 16,
  parameter int INIT_DUTY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_target,
  input  logic          cmd_load,
  input  logic          abort,
  output logic          pwm_load,
  output logic [DW-1:0] pwm_duty,
  output logic          pwm_inc,
  output logic          pwm_dec,
  output logic [DW-1:0] cur_duty,
  output logic          busy,
  output logic          done
);

  import pwm_pkg::*;

  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] INIT_VAL = DW'(INIT_DUTY);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [DW-1:0] tgt;
  logic          step_up;
  logic [DW-1:0] step_to;
  logic          step_tc;
  logic          accept;

  assign accept  = cmd_valid && cmd_ready;
  assign step_up = tgt > cur_duty;
  assign step_to = step_up ? cur_duty + ONE : cur_duty - ONE;

  // Cleared on every entry into WAIT so each step gets a full STEP_DIV interval.
  pwm_step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr ((state == S_IDLE) || (state == S_STEP)),
    .en  (state == S_WAIT),
    .tc  (step_tc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          if (cmd_load)                    state_nxt = S_LOAD;
          else if (cmd_target == cur_duty) state_nxt = S_FIN;
          else                             state_nxt = S_WAIT;
        end
      end
      S_LOAD: state_nxt = S_FIN;
      S_WAIT: begin
        if (abort)        state_nxt = S_FIN;
        else if (step_tc) state_nxt = S_STEP;
      end
      S_STEP: begin
        if (abort || (step_to == tgt)) state_nxt = S_FIN;
        else                           state_nxt = S_WAIT;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      tgt       <= '0;
      cur_duty  <= '0;
      pwm_load  <= 1'b0;
      pwm_duty  <= INIT_VAL;
      pwm_inc   <= 1'b0;
      pwm_dec   <= 1'b0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      pwm_load  <= 1'b0;
      pwm_inc   <= 1'b0;
      pwm_dec   <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_INIT: begin
          pwm_load <= 1'b1;
          pwm_duty <= INIT_VAL;
          cur_duty <= INIT_VAL;
        end
        S_IDLE: begin
          if (accept) tgt <= cmd_target;
        end
        S_LOAD: begin
          pwm_load <= 1'b1;
          pwm_duty <= tgt;
          cur_duty <= tgt;
        end
        S_STEP: begin
          // abort wins over a step due in the same cycle
          if (!abort) begin
            pwm_inc  <= step_up;
            pwm_dec  <= !step_up;
            cur_duty <= step_to;
          end
        end
        S_FIN:   done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (DW=3, STEP_DIV=4, INIT_DUTY=0) with a
// saturating generator model that the shadow duty is compared against every cycle.
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_target;
  logic       cmd_load;
  logic       abort;
  logic       pwm_load;
  logic [2:0] pwm_duty;
  logic       pwm_inc;
  logic       pwm_dec;
  logic [2:0] cur_duty;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [2:0] gen = 3'd0;
  bit synced = 0;

  pwm_ramp_ctrl #(.DW(3), .STEP_DIV(4), .INIT_DUTY(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_load   (cmd_load),
    .abort      (abort),
    .pwm_load   (pwm_load),
    .pwm_duty   (pwm_duty),
    .pwm_inc    (pwm_inc),
    .pwm_dec    (pwm_dec),
    .cur_duty   (cur_duty),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // generator model: sync load, saturating inc/dec
  always @(posedge clk) begin
    if (pwm_load)                   gen <= pwm_duty;
    else if (pwm_inc && gen != 3'd7) gen <= gen + 3'd1;
    else if (pwm_dec && gen != 3'd0) gen <= gen - 3'd1;
  end

  typedef struct {
    logic [2:0] tgt;
    logic       ld;
    int         n_inc;
    int         n_dec;
    int         n_ld;
    int         lat;
    logic [2:0] cur;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock; samples on the falling edge and checks exclusivity and shadow
  task automatic tick();
    logic [2:0] proj;
    @(negedge clk);
    proj = pwm_load ? pwm_duty : pwm_inc ? gen + 3'd1 : pwm_dec ? gen - 3'd1 : gen;
    chk("pulse_mutex", int'(pwm_inc) + int'(pwm_dec) + int'(pwm_load), int'(pwm_inc | pwm_dec | pwm_load));
    if (pwm_load) synced = 1;
    if (synced) chk("shadow_vs_gen", cur_duty, proj);
  endtask

  task automatic do_cmd(input logic [2:0] t, input logic ld,
                        output int n_inc, output int n_dec, output int n_ld,
                        output int lat, output int gap_err, output int ld_duty,
                        output int rdy_done);
    int k;
    int last;
    k = 0;
    while (!cmd_ready && k < 100) begin tick(); k++; end
    chk("ready_wait", int'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_target = t; cmd_load = ld;
    @(posedge clk);
    n_inc = 0; n_dec = 0; n_ld = 0; lat = -1; gap_err = 0; ld_duty = -1; rdy_done = 0;
    last = 0; k = 0;
    while (lat < 0 && k < 200) begin
      tick();
      if (k == 0) cmd_valid = 1'b0;
      if (pwm_inc || pwm_dec) begin
        if (k - last != 5) gap_err++;
        last = k;
      end
      if (pwm_inc) n_inc++;
      if (pwm_dec) n_dec++;
      if (pwm_load) begin n_ld++; ld_duty = int'(pwm_duty); end
      if (done) begin lat = k; rdy_done = int'(cmd_ready); end
      k++;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int ni, nd, nl, lat, ge, ldd, rd, k;
    bit ab;

    vecs[0] = '{3'd3, 1'b0, 3, 0, 0, 16, 3'd3};
    vecs[1] = '{3'd6, 1'b1, 0, 0, 1,  2, 3'd6};
    vecs[2] = '{3'd2, 1'b0, 0, 4, 0, 21, 3'd2};
    vecs[3] = '{3'd2, 1'b0, 0, 0, 0,  1, 3'd2};
    vecs[4] = '{3'd0, 1'b1, 0, 0, 1,  2, 3'd0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_target = 3'd0; cmd_load = 1'b0; abort = 1'b0;
    tick(); tick();
    chk("rst_pwm_load", int'(pwm_load), 0);
    chk("rst_pwm_duty", int'(pwm_duty), 0);
    chk("rst_cur_duty", int'(cur_duty), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_inc_dec", int'(pwm_inc | pwm_dec), 0);

    rst = 1'b0;
    tick();
    chk("init_pwm_load", int'(pwm_load), 1);
    chk("init_pwm_duty", int'(pwm_duty), 0);
    chk("init_cur_duty", int'(cur_duty), 0);
    chk("init_done", int'(done), 0);
    tick();
    chk("init_load_once", int'(pwm_load), 0);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 5; i++) begin
      do_cmd(vecs[i].tgt, vecs[i].ld, ni, nd, nl, lat, ge, ldd, rd);
      chk($sformatf("v%0d_inc", i), ni, vecs[i].n_inc);
      chk($sformatf("v%0d_dec", i), nd, vecs[i].n_dec);
      chk($sformatf("v%0d_load", i), nl, vecs[i].n_ld);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_cur", i), int'(cur_duty), int'(vecs[i].cur));
      chk($sformatf("v%0d_ready_at_done", i), rd, 1);
      if (vecs[i].ld) chk($sformatf("v%0d_load_duty", i), ldd, int'(vecs[i].tgt));
      else            chk($sformatf("v%0d_step_gap", i), ge, 0);
    end

    // ramp 0->7, abort after the 2nd inc, with a follow-up command held meanwhile
    cmd_valid = 1'b1; cmd_target = 3'd7; cmd_load = 1'b0;
    @(posedge clk);
    ni = 0; nd = 0; nl = 0; lat = -1; rd = 0; ab = 0; k = 0;
    while (lat < 0 && k < 100) begin
      tick();
      if (k == 0) begin cmd_target = 3'd5; cmd_load = 1'b1; end
      if (ab) abort = 1'b0;
      if (pwm_inc) ni++;
      if (pwm_dec) nd++;
      if (pwm_load) nl++;
      if (ni == 2 && !ab) begin abort = 1'b1; ab = 1; end
      if (done) begin lat = k; rd = int'(cmd_ready); end
      k++;
    end
    chk("abort_inc", ni, 2);
    chk("abort_dec", nd, 0);
    chk("abort_no_early_load", nl, 0);
    chk("abort_latency", lat, 12);
    chk("abort_cur", int'(cur_duty), 2);
    chk("abort_ready", rd, 1);
    @(posedge clk);
    tick();
    cmd_valid = 1'b0;
    chk("held_busy", int'(busy), 1);
    tick();
    chk("held_pwm_load", int'(pwm_load), 1);
    chk("held_pwm_duty", int'(pwm_duty), 5);
    tick();
    chk("held_done", int'(done), 1);
    chk("held_cur", int'(cur_duty), 5);

    // reset in the middle of a 5->0 ramp
    cmd_valid = 1'b1; cmd_target = 3'd0; cmd_load = 1'b0;
    @(posedge clk);
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 0) cmd_valid = 1'b0;
    end
    chk("mid_ramp_cur", int'(cur_duty), 4);
    chk("mid_ramp_busy", int'(busy), 1);
    rst = 1'b1; synced = 0;
    #1;
    chk("async_rst_cur", int'(cur_duty), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(cmd_ready), 0);
    chk("async_rst_pulses", int'(pwm_inc | pwm_dec | pwm_load), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reinit_pwm_load", int'(pwm_load), 1);
    chk("reinit_pwm_duty", int'(pwm_duty), 0);
    tick();
    chk("reinit_gen", int'(gen), 0);
    chk("reinit_ready", int'(cmd_ready), 1);
    do_cmd(3'd1, 1'b0, ni, nd, nl, lat, ge, ldd, rd);
    chk("recover_inc", ni, 1);
    chk("recover_latency", lat, 6);
    chk("recover_cur", int'(cur_duty), 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
